detection_state_machine: RTL and testbench

//  Top-level sequencer of the face-detection pipeline: idle -> capture one frame -> classify -> idle.

---
 rtl/detection_state_machine_pkg.sv | 20 ++
 rtl/detection_state_machine_if.sv | 29 ++
 rtl/detection_state_machine_rise_detect.sv | 28 ++
 rtl/detection_state_machine.sv | 93 +++++++++
 tb/tb_detection_state_machine.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/detection_state_machine_pkg.sv
// Shared types and constants for the face-detection sequencer (package det_pkg).
// State encoding, default BRAM geometry and the default detection-counter width live here.
package det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DETECT  = 2'd2
    } state_e;

    localparam int ADDR_W      = 15;
    localparam int CNT_W       = 8;
    localparam int FRAME_WORDS = 19200;

    // Port A may only write while a frame is being captured.
    function automatic logic port_a_write_allowed(input state_e st);
        return (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/detection_state_machine_if.sv
// Handshake and BRAM port-A bundle between the sequencer and its neighbours.
// The master side drives the status/address inputs; the slave side is the sequencer itself.
interface detection_state_machine_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 8
);
    logic              cap_done;
    logic              detect_done;
    logic              continue_in;
    logic              write_en_in;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] classifier_rd_addr;

    logic              detect_en;
    logic [ADDR_W-1:0] address_a_out;
    logic              write_en_out;
    logic [1:0]        state_out;
    logic [CNT_W-1:0]  detect_count;

    modport master (
        output cap_done, detect_done, continue_in, write_en_in, wr_addr, classifier_rd_addr,
        input  detect_en, address_a_out, write_en_out, state_out, detect_count
    );

    modport slave (
        input  cap_done, detect_done, continue_in, write_en_in, wr_addr, classifier_rd_addr,
        output detect_en, address_a_out, write_en_out, state_out, detect_count
    );
endinterface

// File: rtl/detection_state_machine_rise_detect.sv
// Registered 0->1 edge detector: one history flop plus a registered one-cycle event pulse.
// A held-high input produces exactly one pulse; reset clears both flops asynchronously.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = din;
        rise_d = din & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;
endmodule

// File: rtl/detection_state_machine.sv
// Face-detection sequencer: IDLE -> CAPTURE -> DETECT, owning BRAM port A.
// Build option AUTO_RUN_EN: DETECT completion re-enters CAPTURE instead of waiting in IDLE.
module detection_state_machine #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 8
) (
    input logic                       clk,
    input logic                       rst,
    detection_state_machine_if.slave  bus
);
    import det_pkg::*;

    logic continue_ev;
    logic cap_ev;
    logic detect_ev;

    state_e           state_q, state_d;
    logic             detect_en_q, detect_en_d;
    logic [CNT_W-1:0] detect_count_q, detect_count_d;

    rise_detect u_continue_rise (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.continue_in),
        .rise  (continue_ev)
    );

    rise_detect u_cap_rise (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.cap_done),
        .rise  (cap_ev)
    );

    rise_detect u_detect_rise (
        .clk   (clk),
        .rst_n (rst),
        .din   (bus.detect_done),
        .rise  (detect_ev)
    );

    // Only the event that matters in the current state is consumed; the rest are dropped.
    always_comb begin
        state_d        = state_q;
        detect_count_d = detect_count_q;
        case (state_q)
            ST_IDLE: begin
                if (continue_ev) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (cap_ev) state_d = ST_DETECT;
            end
            ST_DETECT: begin
                if (detect_ev) begin
`ifdef AUTO_RUN_EN
                    state_d = ST_CAPTURE;
`else
                    state_d = ST_IDLE;
`endif
                    detect_count_d = detect_count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        detect_en_d = (state_d == ST_DETECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            detect_en_q    <= 1'b0;
            detect_count_q <= '0;
        end else begin
            state_q        <= state_d;
            detect_en_q    <= detect_en_d;
            detect_count_q <= detect_count_d;
        end
    end

    // Port-A mux follows the state register directly, so reset kills writes immediately.
    always_comb begin
        bus.address_a_out = bus.classifier_rd_addr;
        bus.write_en_out  = 1'b0;
        if (port_a_write_allowed(state_q)) begin
            bus.address_a_out = bus.wr_addr;
            bus.write_en_out  = bus.write_en_in;
        end
    end

    assign bus.state_out    = state_q;
    assign bus.detect_en    = detect_en_q;
    assign bus.detect_count = detect_count_q;
endmodule

// File: tb/tb_detection_state_machine.sv
// Self-checking bench for detection_state_machine: directed steps plus random traffic against a behavioural model.
module tb_detection_state_machine;
    localparam int AW = 15;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    detection_state_machine_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    detection_state_machine #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: phase 0 idle, 1 capture, 2 detect.
    int m_phase;
    int m_count;
    bit h_cont, h_cap, h_det;
    bit e_cont, e_cap, e_det;
`ifdef AUTO_RUN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        h_cont = 0; h_cap = 0; h_det = 0;
        e_cont = 0; e_cap = 0; e_det = 0;
    endtask

    task automatic compare_all(input string tag);
        int exp_addr;
        int exp_we;
        exp_addr = (m_phase == 1) ? int'(bus.wr_addr) : int'(bus.classifier_rd_addr);
        exp_we   = (m_phase == 1) ? int'(bus.write_en_in) : 0;
        check({tag, ".state"}, 32'(bus.state_out), 32'(m_phase));
        check({tag, ".detect_en"}, 32'(bus.detect_en), 32'(m_phase == 2));
        check({tag, ".count"}, 32'(bus.detect_count), 32'(m_count));
        check({tag, ".addr"}, 32'(bus.address_a_out), 32'(exp_addr));
        check({tag, ".we"}, 32'(bus.write_en_out), 32'(exp_we));
    endtask

    // One clock: an edge sampled on the previous clock acts on this one.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_phase == 0 && e_cont) m_phase = 1;
            else if (m_phase == 1 && e_cap) m_phase = 2;
            else if (m_phase == 2 && e_det) begin
                m_phase = AUTO ? 1 : 0;
                m_count = (m_count + 1) % (1 << CW);
            end
            e_cont = bus.continue_in & !h_cont;
            e_cap  = bus.cap_done & !h_cap;
            e_det  = bus.detect_done & !h_det;
            h_cont = bus.continue_in;
            h_cap  = bus.cap_done;
            h_det  = bus.detect_done;
        end
        #1;
        compare_all(tag);
    endtask

    task automatic pulse(input int which, input string tag);
        case (which)
            0: bus.continue_in = 1'b1;
            1: bus.cap_done    = 1'b1;
            default: bus.detect_done = 1'b1;
        endcase
        tick(tag);
        bus.continue_in = 1'b0;
        bus.cap_done    = 1'b0;
        bus.detect_done = 1'b0;
        tick(tag);
    endtask

    int cnt_before;

    initial begin
        model_reset();
        bus.cap_done = 0; bus.detect_done = 0; bus.continue_in = 0;
        bus.write_en_in = 0; bus.wr_addr = '0; bus.classifier_rd_addr = '0;

        // Power-on reset.
        repeat (3) tick("por");
        #2 rst = 1'b1;
        tick("rel");

        // Start a frame.
        pulse(0, "start");
        check("start.state_explicit", 32'(bus.state_out), 32'd1);
        bus.wr_addr = 15'h1234;
        bus.write_en_in = 1'b1;
        #1;
        compare_all("cap_mux");
        check("cap_mux.addr_explicit", 32'(bus.address_a_out), 32'h1234);
        check("cap_mux.we_explicit", 32'(bus.write_en_out), 32'd1);

        // cap_done held high: one transition only; continue ignored in DETECT.
        bus.cap_done = 1'b1;
        tick("cap_hold");
        tick("cap_hold");
        check("detect.state_explicit", 32'(bus.state_out), 32'd2);
        check("detect.en_explicit", 32'(bus.detect_en), 32'd1);
        bus.classifier_rd_addr = 15'd9599;
        #1;
        check("det_mux.addr_explicit", 32'(bus.address_a_out), 32'd9599);
        check("det_mux.we_explicit", 32'(bus.write_en_out), 32'd0);
        repeat (8) tick("cap_held");
        pulse(0, "cont_in_detect");
        repeat (3) tick("cont_in_detect");
        check("cont_in_detect.state", 32'(bus.state_out), 32'd2);
        bus.cap_done = 1'b0;
        tick("cap_low");

        // Finish detection.
        pulse(2, "det_done");
        check("det_done.count_explicit", 32'(bus.detect_count), 32'd1);
        check("det_done.en_explicit", 32'(bus.detect_en), 32'd0);
        check("det_done.state_explicit", 32'(bus.state_out), AUTO ? 32'd1 : 32'd0);
        repeat (100) tick("idle_hold");
        check("idle_hold.state", 32'(bus.state_out), AUTO ? 32'd1 : 32'd0);

        // 256 full phases bring the counter back round.
        cnt_before = m_count;
        for (int i = 0; i < 256; i++) begin
            if (m_phase == 0) pulse(0, "loop_start");
            if (m_phase == 1) pulse(1, "loop_cap");
            pulse(2, "loop_det");
        end
        check("wrap.count_explicit", 32'(bus.detect_count), 32'(cnt_before));

        // Asynchronous reset in the middle of CAPTURE.
        if (m_phase == 0) pulse(0, "pre_rst");
        bus.write_en_in = 1'b1;
        bus.wr_addr = 15'h0abc;
        #1;
        check("pre_rst.we", 32'(bus.write_en_out), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst.state", 32'(bus.state_out), 32'd0);
        check("rst.we", 32'(bus.write_en_out), 32'd0);
        check("rst.en", 32'(bus.detect_en), 32'd0);
        check("rst.count", 32'(bus.detect_count), 32'd0);
        model_reset();
        tick("in_rst");
        #2 rst = 1'b1;

        // Stray events in IDLE are ignored.
        pulse(1, "idle_cap");
        pulse(2, "idle_det");
        repeat (3) tick("idle_stray");
        check("idle_stray.state", 32'(bus.state_out), 32'd0);

        // Random traffic, including simultaneous events.
        for (int i = 0; i < 800; i++) begin
            bus.continue_in        = ($urandom_range(0, 5) == 0);
            bus.cap_done           = ($urandom_range(0, 5) == 0);
            bus.detect_done        = ($urandom_range(0, 5) == 0);
            bus.write_en_in        = 1'($urandom_range(0, 1));
            bus.wr_addr            = 15'($urandom);
            bus.classifier_rd_addr = 15'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
